// File: rtl/mul_seq_param_if.sv
// -----------------------------------------------------------------------------
// mul_seq_param_if
// Handshake / operand / result bundle for the iterative multiplier.
//   master : drives en, abort, a_sgn, b_sgn, a, b; observes results
//   slave  : the multiplier itself
// Signals:
//   en        start request, accepted when en & ready
//   abort     cancel the operation in flight
//   a_sgn     a is two's complement when 1
//   b_sgn     b is two's complement when 1
//   a, b      operands (DWIDTH bits)
//   ready     a new operation can be accepted this cycle
//   complete  one-cycle pulse when res_*/crf_* were updated
//   res_hi    product bits [2*DWIDTH-1:DWIDTH]
//   res_lo    product bits [DWIDTH-1:0]
//   crf_hi    {lt,gt,eq,ov} of res_hi (ov always 0)
//   crf_lo    {lt,gt,eq,ov} of res_lo (ov = product does not fit DWIDTH bits)
// -----------------------------------------------------------------------------
interface mul_seq_param_if #(
  parameter int DWIDTH = 32
);
  logic              en;
  logic              abort;
  logic              a_sgn;
  logic              b_sgn;
  logic [DWIDTH-1:0] a;
  logic [DWIDTH-1:0] b;
  logic              ready;
  logic              complete;
  logic [DWIDTH-1:0] res_hi;
  logic [DWIDTH-1:0] res_lo;
  logic [3:0]        crf_hi;
  logic [3:0]        crf_lo;

  modport master (
    output en, abort, a_sgn, b_sgn, a, b,
    input  ready, complete, res_hi, res_lo, crf_hi, crf_lo
  );

  modport slave (
    input  en, abort, a_sgn, b_sgn, a, b,
    output ready, complete, res_hi, res_lo, crf_hi, crf_lo
  );
endinterface

// File: rtl/mul_seq_param.sv
// -----------------------------------------------------------------------------
// mul_seq_param
// Iterative shift-add integer multiplier. Retires BITS_PER_CYCLE multiplier
// bits per cycle, LSB first, and returns the full 2*DWIDTH product as hi/lo
// words together with {lt,gt,eq,ov} compare fields. Per-operand signed flags
// cover unsigned, signed and mixed-signedness multiplies on one datapath.
//
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    mul_seq_param_if.slave (en/abort/a_sgn/b_sgn/a/b in,
//          ready/complete/res_hi/res_lo/crf_hi/crf_lo out)
//
// Optional feature macro: MUL_EARLY_TERM_EN
//   When defined, the operation finishes as soon as all remaining multiplier
//   bits are zero; the accumulator is then aligned with one arithmetic shift.
//   When undefined, latency is fixed at CYCLES+1 and no shifter is built.
//
// Accumulator scheme: after k digits the accumulator holds
//   P_k * 2^(DWIDTH - k*BITS_PER_CYCLE)
// so each step adds a*digit at weight 2^DWIDTH and shifts right arithmetically.
// The bits dropped by the shift are always zero, and after CYCLES steps the
// accumulator equals the exact product.
// -----------------------------------------------------------------------------
module mul_seq_param #(
  parameter int DWIDTH         = 32,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_seq_param_if.slave bus
);

  localparam int CYCLES = DWIDTH / BITS_PER_CYCLE;
  localparam int CNTW   = $clog2(CYCLES + 1);
  localparam int AW     = 2 * DWIDTH + 1;                   // accumulator width
  localparam int PW     = DWIDTH + BITS_PER_CYCLE + 2;      // a * digit width
  localparam int TW     = 2 * DWIDTH + BITS_PER_CYCLE + 2;  // pre-shift sum width

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_BUSY = 3'b010,
    S_DONE = 3'b100
  } state_e;

  state_e               state_q, state_d;
  logic [DWIDTH-1:0]    a_q, a_d;
  logic [DWIDTH-1:0]    b_sh_q, b_sh_d;
  logic                 a_sgn_q, a_sgn_d;
  logic                 b_sgn_q, b_sgn_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [DWIDTH-1:0]    res_hi_q, res_hi_d;
  logic [DWIDTH-1:0]    res_lo_q, res_lo_d;
  logic [3:0]           crf_hi_q, crf_hi_d;
  logic [3:0]           crf_lo_q, crf_lo_d;

  logic                 accept_s;
  logic                 finish_s;
  logic                 last_s;
  logic                 rest_zero_s;
  logic                 done_s;
  logic                 a_top_s;
  logic                 d_top_s;
  logic signed [PW-1:0] a_ext_s;
  logic signed [PW-1:0] digit_s;
  logic signed [PW-1:0] prod_s;
  logic signed [TW-1:0] sum_s;
  logic signed [AW-1:0] acc_step_s;
  logic signed [AW-1:0] acc_fin_s;
  logic [DWIDTH-1:0]    prod_hi_s;
  logic [DWIDTH-1:0]    prod_lo_s;
  logic                 ov_s;

`ifdef MUL_EARLY_TERM_EN
  localparam int SHW = $clog2(2 * DWIDTH + 1);
  logic [CNTW-1:0] remain_s;
  logic [SHW-1:0]  sh_amt_s;
`endif

  // {lt,gt,eq,ov} compare field of one result word
  function automatic logic [3:0] crf_f(input logic [DWIDTH-1:0] w, input logic ov);
    logic lt;
    logic eq;
    logic gt;
    lt = w[DWIDTH-1];
    eq = (w == {DWIDTH{1'b0}});
    gt = ~lt & ~eq;
    return {lt, gt, eq, ov};
  endfunction

  // Multiply-accumulate step for the current digit and final alignment
  always_comb begin
    last_s  = (cnt_q == CNTW'(CYCLES - 1));
    a_top_s = a_sgn_q & a_q[DWIDTH-1];
    // only the most significant digit of a signed b carries negative weight
    d_top_s = last_s & b_sgn_q & b_sh_q[BITS_PER_CYCLE-1];
    a_ext_s = {{(BITS_PER_CYCLE + 2){a_top_s}}, a_q};
    digit_s = {{(PW - BITS_PER_CYCLE){d_top_s}}, b_sh_q[BITS_PER_CYCLE-1:0]};
    prod_s  = a_ext_s * digit_s;
    sum_s   = {{(TW - AW){acc_q[AW-1]}}, acc_q}
            + ({{(TW - PW){prod_s[PW-1]}}, prod_s} << DWIDTH);
    acc_step_s = AW'(sum_s >>> BITS_PER_CYCLE);
`ifdef MUL_EARLY_TERM_EN
    // remaining digits are all zero: skip them with one arithmetic shift
    rest_zero_s = ((b_sh_q >> BITS_PER_CYCLE) == {DWIDTH{1'b0}});
    remain_s    = CNTW'(CYCLES - 1) - cnt_q;
    sh_amt_s    = SHW'(remain_s) * SHW'(BITS_PER_CYCLE);
    acc_fin_s   = acc_step_s >>> sh_amt_s;
`else
    rest_zero_s = 1'b0;
    acc_fin_s   = acc_step_s;
`endif
    done_s    = last_s | rest_zero_s;
    prod_hi_s = DWIDTH'(acc_fin_s >> DWIDTH);
    prod_lo_s = DWIDTH'(acc_fin_s);
    ov_s      = (a_sgn_q | b_sgn_q) ? (prod_hi_s != {DWIDTH{prod_lo_s[DWIDTH-1]}})
                                    : (prod_hi_s != {DWIDTH{1'b0}});
  end

  // Next-state logic; an illegal one-hot code falls back to S_IDLE
  always_comb begin
    state_d  = S_IDLE;
    accept_s = 1'b0;
    finish_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.en) begin
          state_d  = S_BUSY;
          accept_s = 1'b1;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_BUSY: begin
        // abort wins over finishing in the same cycle
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (done_s) begin
          state_d  = S_DONE;
          finish_s = 1'b1;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE: begin
        if (bus.en) begin
          state_d  = S_BUSY;
          accept_s = 1'b1;
        end else begin
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Operand latch, accumulator update and result capture
  always_comb begin
    a_d      = a_q;
    b_sh_d   = b_sh_q;
    a_sgn_d  = a_sgn_q;
    b_sgn_d  = b_sgn_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    crf_hi_d = crf_hi_q;
    crf_lo_d = crf_lo_q;
    if (accept_s) begin
      a_d     = bus.a;
      b_sh_d  = bus.b;
      a_sgn_d = bus.a_sgn;
      b_sgn_d = bus.b_sgn;
      cnt_d   = {CNTW{1'b0}};
      acc_d   = {AW{1'b0}};
    end else if (state_q == S_BUSY) begin
      b_sh_d = b_sh_q >> BITS_PER_CYCLE;
      cnt_d  = cnt_q + CNTW'(1);
      if (done_s) begin
        acc_d = acc_fin_s;
      end else begin
        acc_d = acc_step_s;
      end
    end else begin
      acc_d = acc_q;
    end
    if (finish_s) begin
      res_hi_d = prod_hi_s;
      res_lo_d = prod_lo_s;
      crf_hi_d = crf_f(prod_hi_s, 1'b0);
      crf_lo_d = crf_f(prod_lo_s, ov_s);
    end else begin
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= {DWIDTH{1'b0}};
      b_sh_q  <= {DWIDTH{1'b0}};
      a_sgn_q <= 1'b0;
      b_sgn_q <= 1'b0;
      cnt_q   <= {CNTW{1'b0}};
      acc_q   <= {AW{1'b0}};
    end else begin
      a_q     <= a_d;
      b_sh_q  <= b_sh_d;
      a_sgn_q <= a_sgn_d;
      b_sgn_q <= b_sgn_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  // Result registers, updated only on the edge entering S_DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_hi_q <= {DWIDTH{1'b0}};
      res_lo_q <= {DWIDTH{1'b0}};
      crf_hi_q <= 4'b0000;
      crf_lo_q <= 4'b0000;
    end else begin
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      crf_hi_q <= crf_hi_d;
      crf_lo_q <= crf_lo_d;
    end
  end

  assign bus.ready    = (state_q == S_IDLE) | (state_q == S_DONE);
  assign bus.complete = (state_q == S_DONE);
  assign bus.res_hi   = res_hi_q;
  assign bus.res_lo   = res_lo_q;
  assign bus.crf_hi   = crf_hi_q;
  assign bus.crf_lo   = crf_lo_q;

  mul_seq_param_chk u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .state    (state_q),
    .ready    (bus.ready),
    .complete (bus.complete),
    .crf_hi   (bus.crf_hi),
    .crf_lo   (bus.crf_lo)
  );

endmodule

// -----------------------------------------------------------------------------
// mul_seq_param_chk
// Structural invariants of the multiplier: one-hot state, complete implies
// ready, and well-formed compare fields whenever a result is presented.
// -----------------------------------------------------------------------------
module mul_seq_param_chk (
  input logic       clk,
  input logic       rst_n,
  input logic [2:0] state,
  input logic       ready,
  input logic       complete,
  input logic [3:0] crf_hi,
  input logic [3:0] crf_lo
);
  a_state_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot(state));
  a_complete_ready: assert property (@(posedge clk) disable iff (!rst_n)
    complete |-> ready);
  a_crf_hi_wellformed: assert property (@(posedge clk) disable iff (!rst_n)
    complete |-> ($onehot(crf_hi[3:1]) && !crf_hi[0]));
  a_crf_lo_wellformed: assert property (@(posedge clk) disable iff (!rst_n)
    complete |-> $onehot(crf_lo[3:1]));
endmodule
